// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the instruction-memory bus, the hazard/branch
// controls and the IF/ID outputs of the fetch stage into one bundle.
// The master modport is the fetch stage itself; the slave modport is the
// surrounding pipeline (instruction memory, hazard unit, EX and decode).
interface fetch_stage_if #(
  parameter int CNT_W = 16
);

  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic             stall_f;
  logic             flush_d;
  logic             branch_taken_e;
  logic [31:0]      branch_target_e;
  logic [31:0]      instr_d;
  logic [31:0]      pc_d;
  logic [31:0]      pc_plus8_d;
  logic             valid_d;
  logic [CNT_W-1:0] perf_fetch_cnt;
  logic [CNT_W-1:0] perf_stall_cnt;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall_f,
    input  flush_d,
    input  branch_taken_e,
    input  branch_target_e,
    output instr_d,
    output pc_d,
    output pc_plus8_d,
    output valid_d,
    output perf_fetch_cnt,
    output perf_stall_cnt
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall_f,
    output flush_d,
    output branch_taken_e,
    output branch_target_e,
    input  instr_d,
    input  pc_d,
    input  pc_plus8_d,
    input  valid_d,
    input  perf_fetch_cnt,
    input  perf_stall_cnt
  );

endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined ARM core.
// Owns the architectural PC and the IF/ID pipeline register, applies EX
// branch redirects and hazard-unit stall/flush requests, and hands decode
// the instruction, its address and its ARM R15 read value (PC+8).
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined;
// otherwise both counter outputs are tied to zero.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000,
  parameter int          CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  logic [31:0] fetchPc_q,   fetchPc_d;
  logic [31:0] decInstr_q,  decInstr_d;
  logic [31:0] decPc_q,     decPc_d;
  logic [31:0] decPcPlus8_q, decPcPlus8_d;
  logic        decValid_q,  decValid_d;
  logic        acceptFetch;
  logic [31:0] pcPlus4;
  logic [31:0] pcPlus8;
  logic        unusedTargetLsbs;

  // The branch target is word-aligned, so its two low bits never matter.
  assign unusedTargetLsbs = ^bus.branch_target_e[1:0];

  assign pcPlus4 = fetchPc_q + 32'd4;
  assign pcPlus8 = fetchPc_q + 32'd8;

  // Next PC and IF/ID contents, resolved in priority order: redirect, stall, flush, advance.
  always_comb begin
    fetchPc_d    = fetchPc_q;
    decInstr_d   = decInstr_q;
    decPc_d      = decPc_q;
    decPcPlus8_d = decPcPlus8_q;
    decValid_d   = decValid_q;
    acceptFetch  = 1'b0;
    if (bus.branch_taken_e) begin
      fetchPc_d  = {bus.branch_target_e[31:2], 2'b00};
      decInstr_d = NOP_INSTR;
      decValid_d = 1'b0;
    end else if (bus.stall_f && !bus.flush_d) begin
      fetchPc_d = fetchPc_q;
    end else if (bus.stall_f && bus.flush_d) begin
      decInstr_d = NOP_INSTR;
      decValid_d = 1'b0;
    end else if (bus.flush_d) begin
      fetchPc_d  = pcPlus4;
      decInstr_d = NOP_INSTR;
      decValid_d = 1'b0;
    end else begin
      fetchPc_d    = pcPlus4;
      decInstr_d   = bus.imem_rdata;
      decPc_d      = fetchPc_q;
      decPcPlus8_d = pcPlus8;
      decValid_d   = 1'b1;
      acceptFetch  = 1'b1;
    end
  end

  // PC and IF/ID register; reset parks fetch at RESET_PC with an invalid bubble in decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc_q    <= RESET_PC;
      decInstr_q   <= NOP_INSTR;
      decPc_q      <= 32'd0;
      decPcPlus8_q <= 32'd8;
      decValid_q   <= 1'b0;
    end else begin
      fetchPc_q    <= fetchPc_d;
      decInstr_q   <= decInstr_d;
      decPc_q      <= decPc_d;
      decPcPlus8_q <= decPcPlus8_d;
      decValid_q   <= decValid_d;
    end
  end

  assign bus.imem_addr  = fetchPc_q;
  assign bus.instr_d    = decInstr_q;
  assign bus.pc_d       = decPc_q;
  assign bus.pc_plus8_d = decPcPlus8_q;
  assign bus.valid_d    = decValid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] perfFetch_q, perfFetch_d;
  logic [CNT_W-1:0] perfStall_q, perfStall_d;

  // Counter increments: accepted fetches, and stalled cycles not overridden by a redirect.
  always_comb begin
    perfFetch_d = perfFetch_q;
    perfStall_d = perfStall_q;
    if (acceptFetch) begin
      perfFetch_d = perfFetch_q + CNT_W'(1);
    end
    if (bus.stall_f && !bus.branch_taken_e) begin
      perfStall_d = perfStall_q + CNT_W'(1);
    end
  end

  // Wrapping performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfFetch_q <= '0;
      perfStall_q <= '0;
    end else begin
      perfFetch_q <= perfFetch_d;
      perfStall_q <= perfStall_d;
    end
  end

  assign bus.perf_fetch_cnt = perfFetch_q;
  assign bus.perf_stall_cnt = perfStall_q;
`else
  logic unusedAcceptFetch;

  assign unusedAcceptFetch  = acceptFetch;
  assign bus.perf_fetch_cnt = '0;
  assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed testbench for fetch_stage.
// The instruction memory returns 0xE3A0_0000 + address for every word.
// Expected counter values follow FETCH_PERF_CNT_EN when it is defined.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam logic [31:0] MEM_BASE = 32'hE3A0_0000;

  logic clk;
  logic rst;
  int   errorCount;
  int   checkCount;

  fetch_stage_if #(.CNT_W(16)) bus ();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP),
    .CNT_W    (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Combinational instruction memory model.
  assign bus.imem_rdata = MEM_BASE + bus.imem_addr;

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the hazard and branch inputs for the next edge.
  task automatic applyStimulus(input logic stall, input logic flush, input logic br, input logic [31:0] target);
    bus.stall_f         = stall;
    bus.flush_d         = flush;
    bus.branch_taken_e  = br;
    bus.branch_target_e = target;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the IF/ID fields in one go.
  task automatic checkIfId(input string tag, input logic [31:0] addr, input logic [31:0] instr,
                           input logic [31:0] pc, input logic [31:0] pc8, input logic valid);
    checkOutput({tag, ".imem_addr"}, bus.imem_addr, addr);
    checkOutput({tag, ".instr_d"}, bus.instr_d, instr);
    checkOutput({tag, ".pc_d"}, bus.pc_d, pc);
    checkOutput({tag, ".pc_plus8_d"}, bus.pc_plus8_d, pc8);
    checkOutput({tag, ".valid_d"}, {31'd0, bus.valid_d}, {31'd0, valid});
  endtask

  // Check both performance counters against expected enabled-build values.
  task automatic checkPerf(input string tag, input int fetchExp, input int stallExp);
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, ".perf_fetch_cnt"}, {16'd0, bus.perf_fetch_cnt}, 32'(fetchExp));
    checkOutput({tag, ".perf_stall_cnt"}, {16'd0, bus.perf_stall_cnt}, 32'(stallExp));
`else
    checkOutput({tag, ".perf_fetch_cnt"}, {16'd0, bus.perf_fetch_cnt}, 32'(fetchExp * 0));
    checkOutput({tag, ".perf_stall_cnt"}, {16'd0, bus.perf_stall_cnt}, 32'(stallExp * 0));
`endif
  endtask

  // Directed test sequence.
  initial begin
    errorCount = 0;
    checkCount = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);

    @(negedge clk);
    checkIfId("reset", 32'h0, NOP, 32'h0, 32'h8, 1'b0);
    checkPerf("reset", 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      checkIfId($sformatf("run%0d", i), 32'(4 * (i + 1)), MEM_BASE + 32'(4 * i),
                32'(4 * i), 32'(4 * i + 8), 1'b1);
    end
    checkPerf("run", 4, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIfId($sformatf("stall%0d", i), 32'h10, MEM_BASE + 32'hC, 32'hC, 32'h14, 1'b1);
    end
    checkPerf("stall", 4, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkIfId("stallRelease", 32'h14, MEM_BASE + 32'h10, 32'h10, 32'h18, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 32'h74);
    tick();
    checkIfId("branchOverStall", 32'h74, NOP, 32'h10, 32'h18, 1'b0);
    checkPerf("branchOverStall", 5, 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkIfId("branchLand", 32'h78, MEM_BASE + 32'h74, 32'h74, 32'h7C, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h4B);
    tick();
    checkOutput("unalignedTarget.imem_addr", bus.imem_addr, 32'h48);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkIfId("unalignedLand", 32'h4C, MEM_BASE + 32'h48, 32'h48, 32'h50, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h20);
    tick();
    checkOutput("toFlushPc.imem_addr", bus.imem_addr, 32'h20);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
    tick();
    checkIfId("flushAlone", 32'h24, NOP, 32'h48, 32'h50, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkIfId("afterFlush", 32'h28, MEM_BASE + 32'h24, 32'h24, 32'h2C, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 32'd0);
    tick();
    checkIfId("stallFlush", 32'h28, NOP, 32'h24, 32'h2C, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkIfId("afterStallFlush", 32'h2C, MEM_BASE + 32'h28, 32'h28, 32'h30, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    checkOutput("toTop.imem_addr", bus.imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    checkIfId("wrap", 32'h0, 32'hE39F_FFFC, 32'hFFFF_FFFC, 32'h4, 1'b1);
    checkPerf("wrap", 10, 4);
    tick();
    checkIfId("afterWrap", 32'h4, MEM_BASE, 32'h0, 32'h8, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 32'h3C);
    tick();
    checkOutput("toResetPc.imem_addr", bus.imem_addr, 32'h3C);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkIfId("asyncReset", 32'h0, NOP, 32'h0, 32'h8, 1'b0);
    checkPerf("asyncReset", 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checkIfId("postReset", 32'h4, MEM_BASE, 32'h0, 32'h8, 1'b1);
    checkPerf("postReset", 1, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
